cpu_sequencer: RTL and testbench

- Parametrised multicycle control sequencer for the simple CPU; next generation of the top-level Moore control path.
- Owns the PC, the instruction register, the one-hot state and all datapath strobes: decoder, ALU, register write, memory read/write.
- Adds data-memory load/store, branch PC update, a memory-wait timeout with fault state, a retired-instruction counter, and graceful stop on enable drop.
- Sits between the memory, decoder, ALU and regs blocks.

---
 rtl/cpu_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multicycle Moore control sequencer: owns PC, IR, retired-instruction count and
// all datapath strobes; adds load/store, branch, memory-wait timeout and fault.
module cpu_sequencer #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] PC_RESET    = '0,
    parameter int unsigned     PC_STEP     = 1,
    parameter int unsigned     MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            mem_rdy,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            dec_halt,
    input  logic            dec_load,
    input  logic            dec_store,
    input  logic            dec_branch,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] alu_y,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] pc,
    output logic [8:0]      state,
    output logic            decod_en,
    output logic            alu_en,
    output logic            wen_regs,
    output logic            halted,
    output logic            fault,
    output logic [XLEN-1:0] instret
);

    typedef enum logic [8:0] {
        S_IDLE   = 9'b0_0000_0001,
        S_FETCH  = 9'b0_0000_0010,
        S_DECODE = 9'b0_0000_0100,
        S_EXEC   = 9'b0_0000_1000,
        S_MEM    = 9'b0_0001_0000,
        S_WB     = 9'b0_0010_0000,
        S_PC_UPD = 9'b0_0100_0000,
        S_HALT   = 9'b0_1000_0000,
        S_FAULT  = 9'b1_0000_0000
    } state_t;

    localparam int unsigned     TW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [XLEN-1:0] STEP     = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ONE      = XLEN'(1);

    state_t          cur_q;
    state_t          nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] ir_q;
    logic [XLEN-1:0] instret_q;
    logic [XLEN-1:0] tgt_q;
    logic            ld_q;
    logic            st_q;
    logic            br_q;
    logic [TW-1:0]   tmo_q;
    logic            tmo_hit;
    logic            mem_wait;

    // The count holds the number of wait cycles already spent; the limit cycle
    // is the one where the count equals MEM_TIMEOUT-1 and mem_rdy is still low.
    assign tmo_hit  = (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST);
    assign mem_wait = ((cur_q == S_FETCH) || (cur_q == S_MEM)) && !mem_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q <= S_IDLE;
        end else begin
            cur_q <= nxt;
        end
    end

    always_comb begin
        nxt = cur_q;
        case (cur_q)
            S_IDLE:   if (enable) nxt = S_FETCH;
            S_FETCH: begin
                if (mem_rdy)      nxt = S_DECODE;
                else if (tmo_hit) nxt = S_FAULT;
            end
            S_DECODE: nxt = dec_halt ? S_HALT : S_EXEC;
            S_EXEC:   nxt = (ld_q || st_q) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_rdy)      nxt = ld_q ? S_WB : S_PC_UPD;
                else if (tmo_hit) nxt = S_FAULT;
            end
            S_WB:     nxt = S_PC_UPD;
            S_PC_UPD: nxt = enable ? S_FETCH : S_IDLE;
            S_HALT:   nxt = S_HALT;
            S_FAULT:  nxt = S_FAULT;
            // A corrupted one-hot code is treated as a fault rather than silently resumed.
            default:  nxt = S_FAULT;
        endcase
    end

    always_comb begin
        mem_addr = '0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        decod_en = 1'b0;
        alu_en   = 1'b0;
        wen_regs = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (cur_q)
            S_FETCH: begin
                mem_addr = pc_q;
                mem_ren  = 1'b1;
            end
            S_DECODE: decod_en = 1'b1;
            S_EXEC:   alu_en   = 1'b1;
            S_MEM: begin
                mem_addr = alu_y;
                mem_ren  = ld_q;
                // Load takes precedence if the decoder ever flags both.
                mem_wen  = st_q && !ld_q;
            end
            S_WB:     wen_regs = 1'b1;
            S_HALT:   halted   = 1'b1;
            S_FAULT:  fault    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            instret_q <= '0;
            tgt_q     <= '0;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            br_q      <= 1'b0;
            tmo_q     <= '0;
        end else begin
            if ((cur_q == S_FETCH) && mem_rdy) begin
                ir_q <= mem_rdata;
            end
            if (cur_q == S_DECODE) begin
                ld_q  <= dec_load;
                st_q  <= dec_store;
                br_q  <= dec_branch;
                tgt_q <= branch_target;
            end
            if (cur_q == S_PC_UPD) begin
                pc_q      <= br_q ? tgt_q : pc_q + STEP;
                instret_q <= instret_q + ONE;
            end
            if (mem_wait) begin
                tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= '0;
            end
        end
    end

    assign state   = cur_q;
    assign pc      = pc_q;
    assign ir      = ir_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-cycle expected state/strobe/address
// words are queued as stimulus is set up and popped against the DUT each cycle.
module tb_cpu_sequencer;

    localparam logic [8:0] S_IDLE  = 9'h001;
    localparam logic [8:0] S_FETCH = 9'h002;
    localparam logic [8:0] S_DEC   = 9'h004;
    localparam logic [8:0] S_EXEC  = 9'h008;
    localparam logic [8:0] S_MEM   = 9'h010;
    localparam logic [8:0] S_WB    = 9'h020;
    localparam logic [8:0] S_PCU   = 9'h040;
    localparam logic [8:0] S_HALT  = 9'h080;
    localparam logic [8:0] S_FAULT = 9'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mem_rdy;
    logic [31:0] mem_rdata;
    logic        dec_halt, dec_load, dec_store, dec_branch;
    logic [31:0] branch_target;
    logic [31:0] alu_y;
    logic [31:0] mem_addr;
    logic        mem_ren, mem_wen;
    logic [31:0] ir, pc, instret;
    logic [8:0]  state;
    logic        decod_en, alu_en, wen_regs, halted, fault;

    int          vectors = 0;
    int          miscompares = 0;
    logic [47:0] sb[$];
    logic [47:0] e;

    cpu_sequencer #(
        .XLEN(32),
        .PC_RESET(32'h100),
        .PC_STEP(1),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .dec_halt(dec_halt), .dec_load(dec_load), .dec_store(dec_store),
        .dec_branch(dec_branch), .branch_target(branch_target), .alu_y(alu_y),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen), .ir(ir), .pc(pc),
        .state(state), .decod_en(decod_en), .alu_en(alu_en), .wen_regs(wen_regs),
        .halted(halted), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] ex(input logic [8:0] st, input logic ren, input logic wen,
                                       input logic [31:0] a);
        return {st, ren, wen, st == S_DEC, st == S_EXEC, st == S_WB, st == S_HALT, st == S_FAULT, a};
    endfunction

    function automatic logic [47:0] obs();
        return {state, mem_ren, mem_wen, decod_en, alu_en, wen_regs, halted, fault, mem_addr};
    endfunction

    task automatic set_dec(input logic h, input logic l, input logic s, input logic b);
        dec_halt = h; dec_load = l; dec_store = s; dec_branch = b;
    endtask

    task automatic push_plain(input logic [31:0] a);
        sb.push_back(ex(S_FETCH, 1'b1, 1'b0, a));
        sb.push_back(ex(S_DEC, 1'b0, 1'b0, '0));
        sb.push_back(ex(S_EXEC, 1'b0, 1'b0, '0));
        sb.push_back(ex(S_WB, 1'b0, 1'b0, '0));
        sb.push_back(ex(S_PCU, 1'b0, 1'b0, '0));
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; mem_rdy = 1'b1; mem_rdata = '0; alu_y = '0;
        branch_target = '0; set_dec(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs() !== ex(S_IDLE, 0, 0, '0)) begin
            miscompares++; $display("FAIL reset_outputs: got %h want %h", obs(), ex(S_IDLE, 0, 0, '0));
        end
        vectors++;
        if ({pc, ir, instret} !== {32'h100, 32'h0, 32'h0}) begin
            miscompares++; $display("FAIL reset_regs: got pc=%h ir=%h instret=%h want 100/0/0", pc, ir, instret);
        end
        rst = 1'b1; enable = 1'b1;
        sb.push_back(ex(S_IDLE, 0, 0, '0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL reset_release: got %h want %h", obs(), e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        set_dec(0, 0, 0, 0); mem_rdy = 1'b1; mem_rdata = 32'hA5A5_0001; alu_y = 32'h77;
        push_plain(32'h100);
        while (sb.size() != 0) begin
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL alu_seq: got %h want %h", obs(), e); end
            @(posedge clk); #1;
        end
        vectors++;
        if ({pc, instret, ir, state} !== {32'h101, 32'h1, 32'hA5A5_0001, S_FETCH}) begin
            miscompares++;
            $display("FAIL alu_retire: got pc=%h instret=%h ir=%h st=%h want 101/1/a5a50001/002", pc, instret, ir, state);
        end
    endtask

    task automatic test_fetch_wait();
        int cyc = 0;
        set_dec(0, 0, 0, 0);
        repeat (3) sb.push_back(ex(S_FETCH, 1'b1, 1'b0, 32'h101));
        push_plain(32'h101);
        while (sb.size() != 0) begin
            mem_rdy   = (cyc >= 3);
            mem_rdata = (cyc == 3) ? 32'h1234_5678 : 32'hDEAD_0000 + 32'(cyc);
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL fetch_wait cyc%0d: got %h want %h", cyc, obs(), e); end
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if ({ir, pc, instret} !== {32'h1234_5678, 32'h102, 32'h2}) begin
            miscompares++; $display("FAIL fetch_wait_ir: got ir=%h pc=%h instret=%h want 12345678/102/2", ir, pc, instret);
        end
    endtask

    task automatic test_load();
        set_dec(0, 1, 0, 0); mem_rdy = 1'b1; alu_y = 32'h40;
        sb.push_back(ex(S_FETCH, 1, 0, 32'h102));
        sb.push_back(ex(S_DEC, 0, 0, '0));
        sb.push_back(ex(S_EXEC, 0, 0, '0));
        sb.push_back(ex(S_MEM, 1, 0, 32'h40));
        sb.push_back(ex(S_WB, 0, 0, '0));
        sb.push_back(ex(S_PCU, 0, 0, '0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL load_seq: got %h want %h", obs(), e); end
            @(posedge clk); #1;
        end
        vectors++;
        if ({pc, instret} !== {32'h103, 32'h3}) begin
            miscompares++; $display("FAIL load_retire: got pc=%h instret=%h want 103/3", pc, instret);
        end
    endtask

    task automatic test_store();
        set_dec(0, 0, 1, 0); mem_rdy = 1'b1; alu_y = 32'h44;
        sb.push_back(ex(S_FETCH, 1, 0, 32'h103));
        sb.push_back(ex(S_DEC, 0, 0, '0));
        sb.push_back(ex(S_EXEC, 0, 0, '0));
        sb.push_back(ex(S_MEM, 0, 1, 32'h44));
        sb.push_back(ex(S_PCU, 0, 0, '0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL store_seq: got %h want %h", obs(), e); end
            @(posedge clk); #1;
        end
        vectors++;
        if ({pc, instret} !== {32'h104, 32'h4}) begin
            miscompares++; $display("FAIL store_retire: got pc=%h instret=%h want 104/4", pc, instret);
        end
    endtask

    task automatic test_branch_wrap();
        logic [31:0] start_pc [3] = '{32'h104, 32'h10, 32'hFFFF_FFFF};
        logic [31:0] tgt      [3] = '{32'h10, 32'hFFFF_FFFF, 32'h5555_5555};
        logic        br       [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] want_pc  [3] = '{32'h10, 32'hFFFF_FFFF, 32'h0};
        mem_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_dec(0, 0, 0, br[k]); branch_target = tgt[k];
            push_plain(start_pc[k]);
            while (sb.size() != 0) begin
                e = sb.pop_front(); vectors++;
                if (obs() !== e) begin miscompares++; $display("FAIL branch_seq%0d: got %h want %h", k, obs(), e); end
                @(posedge clk); #1;
            end
            vectors++;
            if ({pc, instret} !== {want_pc[k], 32'(5 + k)}) begin
                miscompares++; $display("FAIL branch_pc%0d: got pc=%h instret=%h want %h/%0d", k, pc, instret, want_pc[k], 5 + k);
            end
        end
    endtask

    task automatic test_enable_drop();
        int cyc = 0;
        set_dec(0, 0, 0, 0); mem_rdy = 1'b1; branch_target = '0;
        push_plain(32'h0);
        sb.push_back(ex(S_IDLE, 0, 0, '0));
        sb.push_back(ex(S_IDLE, 0, 0, '0));
        while (sb.size() != 0) begin
            if (cyc == 2) enable = 1'b0;
            if (cyc == 6) enable = 1'b1;
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL enable_drop cyc%0d: got %h want %h", cyc, obs(), e); end
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if ({pc, instret} !== {32'h1, 32'h8}) begin
            miscompares++; $display("FAIL enable_drop_retire: got pc=%h instret=%h want 1/8", pc, instret);
        end
    endtask

    task automatic test_reset_mid_mem();
        set_dec(0, 0, 1, 0); mem_rdy = 1'b1; alu_y = 32'h80;
        sb.push_back(ex(S_FETCH, 1, 0, 32'h1));
        sb.push_back(ex(S_DEC, 0, 0, '0));
        sb.push_back(ex(S_EXEC, 0, 0, '0));
        sb.push_back(ex(S_MEM, 0, 1, 32'h80));
        for (int k = 0; k < 4; k++) begin
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL mid_mem_seq%0d: got %h want %h", k, obs(), e); end
            if (k < 3) begin @(posedge clk); #1; end
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (obs() !== ex(S_IDLE, 0, 0, '0)) begin
            miscompares++; $display("FAIL mid_mem_async: got %h want %h", obs(), ex(S_IDLE, 0, 0, '0));
        end
        vectors++;
        if ({pc, ir, instret} !== {32'h100, 32'h0, 32'h0}) begin
            miscompares++; $display("FAIL mid_mem_regs: got pc=%h ir=%h instret=%h want 100/0/0", pc, ir, instret);
        end
        @(posedge clk); #1;
        rst = 1'b1; set_dec(0, 0, 0, 0); enable = 1'b1;
        sb.push_back(ex(S_IDLE, 0, 0, '0));
        while (sb.size() != 0) begin
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL mid_mem_release: got %h want %h", obs(), e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        int cyc = 0;
        set_dec(1, 0, 0, 0); mem_rdy = 1'b1; mem_rdata = 32'hF000_0000;
        sb.push_back(ex(S_FETCH, 1, 0, 32'h100));
        sb.push_back(ex(S_DEC, 0, 0, '0));
        repeat (5) sb.push_back(ex(S_HALT, 0, 0, '0));
        while (sb.size() != 0) begin
            if (cyc >= 2) enable = cyc[0];
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL halt_seq cyc%0d: got %h want %h", cyc, obs(), e); end
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if ({pc, instret} !== {32'h100, 32'h0}) begin
            miscompares++; $display("FAIL halt_regs: got pc=%h instret=%h want 100/0", pc, instret);
        end
    endtask

    task automatic test_timeout_limit();
        int cyc = 0;
        rst = 1'b0; @(posedge clk); #1;
        rst = 1'b1; enable = 1'b1; set_dec(0, 0, 0, 0); mem_rdy = 1'b0; mem_rdata = 32'hCAFE_0015;
        sb.push_back(ex(S_IDLE, 0, 0, '0));
        repeat (14) sb.push_back(ex(S_FETCH, 1, 0, 32'h100));
        push_plain(32'h100);
        while (sb.size() != 0) begin
            mem_rdy = (cyc >= 15);
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL tmo_limit cyc%0d: got %h want %h", cyc, obs(), e); end
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if ({ir, pc, instret} !== {32'hCAFE_0015, 32'h101, 32'h1}) begin
            miscompares++; $display("FAIL tmo_limit_retire: got ir=%h pc=%h instret=%h want cafe0015/101/1", ir, pc, instret);
        end
    endtask

    task automatic test_timeout_fault();
        int cyc = 0;
        mem_rdy = 1'b0;
        repeat (15) sb.push_back(ex(S_FETCH, 1, 0, 32'h101));
        repeat (4) sb.push_back(ex(S_FAULT, 0, 0, '0));
        while (sb.size() != 0) begin
            if (cyc >= 15) begin mem_rdy = 1'b1; enable = cyc[0]; end
            e = sb.pop_front(); vectors++;
            if (obs() !== e) begin miscompares++; $display("FAIL tmo_fault cyc%0d: got %h want %h", cyc, obs(), e); end
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if ({pc, instret} !== {32'h101, 32'h1}) begin
            miscompares++; $display("FAIL tmo_fault_regs: got pc=%h instret=%h want 101/1", pc, instret);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_fetch_wait();
        test_load();
        test_store();
        test_branch_wrap();
        test_enable_drop();
        test_reset_mid_mem();
        test_halt();
        test_timeout_limit();
        test_timeout_fault();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
